// File: rtl/lsu_pkg.sv
// Shared types for the LSU memory initiator: store-buffer entry layout and bus widths.
// Consumed by lsu_store_buffer and lsu_mem_initiator.
package lsu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    function automatic logic word_aligned(input logic [1:0] addr_lo);
        return (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/lsu_store_buffer.sv
// In-order store buffer: circular FIFO of {addr,data} with a youngest-match search
// by word address, present only when STORE_FWD_EN is defined.
module lsu_store_buffer
    import lsu_pkg::*;
#(
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  sb_entry_t         push_entry_i,
    input  logic              pop_i,
`ifdef STORE_FWD_EN
    input  logic [ADDR_W-1:2] fwd_word_i,
    output logic              fwd_hit_o,
    output logic [DATA_W-1:0] fwd_data_o,
`endif
    output sb_entry_t         head_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    sb_entry_t        entries_q [SB_DEPTH];

    // Pointers wrap naturally because SB_DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) tail_d = tail_q + PTR_W'(1);
        if (pop_i)  head_d = head_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: only entries below count_q are ever observed.
    always_ff @(posedge clk) begin
        if (push_i) entries_q[tail_q] <= push_entry_i;
    end

    assign head_o  = entries_q[head_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(SB_DEPTH));

`ifdef STORE_FWD_EN
    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (entries_q[head_q + PTR_W'(i)].addr[ADDR_W-1:2] == fwd_word_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = entries_q[head_q + PTR_W'(i)].data;
            end
        end
    end
`endif

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for the single-port data memory: load slot, store buffer, port arbiter
// and load response register. Define STORE_FWD_EN to let loads bypass buffered stores.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    parameter int TAG_W    = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic              sb_drain_en,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic              st_err,
    output logic              sb_empty,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [31:0]       Address,
    output logic [31:0]       Write_Data,
    input  logic [31:0]       Read_Data
);

    logic              ld_valid_q, ld_valid_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [TAG_W-1:0]  ld_tag_q, ld_tag_d;

    logic              resp_valid_q, resp_valid_d;
    logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic              st_err_q, st_err_d;

    sb_entry_t         push_entry;
    sb_entry_t         head_entry;
    logic              sb_full;
    logic              sb_push;
    logic              sb_pop;

    logic              req_fire;
    logic              ld_accept;
    logic              st_bad;
    logic              ld_aligned;
    logic              ld_ok;
    logic              ld_go;
    logic              mem_rd;
    logic              drain;
    logic [DATA_W-1:0] ld_data;

    // Handshakes: a request transfers on a cycle with req_valid & req_ready; a response
    // transfers on resp_valid & resp_ready and is held stable until then.
    assign req_ready = !ld_valid_q && !sb_full;
    assign req_fire  = req_valid && req_ready;
    assign ld_accept = req_fire && !req_is_store;
    assign sb_push   = req_fire && req_is_store && word_aligned(req_addr[1:0]);
    assign st_bad    = req_fire && req_is_store && !word_aligned(req_addr[1:0]);

    assign push_entry = '{addr: req_addr, data: req_wdata};
    assign ld_aligned = word_aligned(ld_addr_q[1:0]);

`ifdef STORE_FWD_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // A full buffer must drain first, otherwise a stream of loads could starve stores.
    assign ld_ok   = !sb_full;
    assign mem_rd  = ld_go && ld_aligned && !fwd_hit;
    assign ld_data = fwd_hit ? fwd_data : Read_Data;
`else
    // Strict ordering: a load waits until every older store has reached memory.
    assign ld_ok   = sb_empty;
    assign mem_rd  = ld_go && ld_aligned;
    assign ld_data = Read_Data;
`endif

    assign ld_go  = ld_valid_q && (!resp_valid_q || resp_ready) && ld_ok;
    assign drain  = !sb_empty && sb_drain_en && !ld_go;
    assign sb_pop = drain;

    lsu_store_buffer #(
        .SB_DEPTH(SB_DEPTH)
    ) u_sb (
        .clk          (clk),
        .reset_n      (reset_n),
        .push_i       (sb_push),
        .push_entry_i (push_entry),
        .pop_i        (sb_pop),
`ifdef STORE_FWD_EN
        .fwd_word_i   (ld_addr_q[ADDR_W-1:2]),
        .fwd_hit_o    (fwd_hit),
        .fwd_data_o   (fwd_data),
`endif
        .head_o       (head_entry),
        .empty_o      (sb_empty),
        .full_o       (sb_full)
    );

    assign MemRead    = mem_rd;
    assign MemWrite   = drain;
    assign Address    = mem_rd ? ld_addr_q : (drain ? head_entry.addr : '0);
    assign Write_Data = drain ? head_entry.data : '0;

    always_comb begin
        ld_valid_d   = ld_valid_q;
        ld_addr_d    = ld_addr_q;
        ld_tag_d     = ld_tag_q;
        resp_valid_d = resp_valid_q;
        resp_tag_d   = resp_tag_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        st_err_d     = st_bad;

        // The slot can only be refilled once it is empty, so accept and issue never collide.
        if (ld_go) begin
            ld_valid_d = 1'b0;
        end else if (ld_accept) begin
            ld_valid_d = 1'b1;
            ld_addr_d  = req_addr;
            ld_tag_d   = req_tag;
        end

        if (ld_go) begin
            resp_valid_d = 1'b1;
            resp_tag_d   = ld_tag_q;
            resp_data_d  = ld_aligned ? ld_data : '0;
            resp_err_d   = !ld_aligned;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_valid_q   <= 1'b0;
            ld_addr_q    <= '0;
            ld_tag_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            st_err_q     <= 1'b0;
        end else begin
            ld_valid_q   <= ld_valid_d;
            ld_addr_q    <= ld_addr_d;
            ld_tag_q     <= ld_tag_d;
            resp_valid_q <= resp_valid_d;
            resp_tag_q   <= resp_tag_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            st_err_q     <= st_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_tag   = resp_tag_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign st_err     = st_err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: directed scenarios then random traffic against an
// architectural memory model (a load returns the latest older store to its word).
module tb_lsu_mem_initiator;

    localparam int TAG_W    = 6;
    localparam int SB_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [TAG_W-1:0]  req_tag;
    logic              sb_drain_en;
    logic              resp_valid;
    logic              resp_ready;
    logic [TAG_W-1:0]  resp_tag;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic              st_err;
    logic              sb_empty;
    logic              MemRead;
    logic              MemWrite;
    logic [31:0]       Address;
    logic [31:0]       Write_Data;
    logic [31:0]       Read_Data;

    always #5 clk = ~clk;

    lsu_mem_initiator #(
        .SB_DEPTH(SB_DEPTH),
        .TAG_W   (TAG_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_tag      (req_tag),
        .sb_drain_en  (sb_drain_en),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_tag     (resp_tag),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .st_err       (st_err),
        .sb_empty     (sb_empty),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Address      (Address),
        .Write_Data   (Write_Data),
        .Read_Data    (Read_Data)
    );

    // Data memory: 64 words, combinational read, write on the clock edge.
    logic [31:0] mem [64];
    assign Read_Data = mem[Address[7:2]];
    always @(posedge clk) begin
        if (MemWrite) mem[Address[7:2]] = Write_Data;
    end

    logic [31:0] shadow [64];
    logic [63:0] exp_wr_q [$];
    logic [38:0] exp_resp_q [$];
    int          tests = 0;
    int          fails = 0;
    int          cyc_n = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          last_rd_cyc = 0;
    int          last_wr_cyc = 0;
    logic        acc = 1'b0;
    logic        st_err_exp = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: settle, score the port and response, apply the model to an accept.
    task automatic cyc();
        logic [63:0] wr;
        logic [38:0] rs;
        #1;
        acc = 1'b0;
        if (MemRead || MemWrite) check("port_excl", 64'(MemRead & MemWrite), 64'd0);
        if (MemRead) begin
            n_rd++;
            last_rd_cyc = cyc_n;
        end
        if (MemWrite) begin
            n_wr++;
            last_wr_cyc = cyc_n;
            if (exp_wr_q.size() == 0) begin
                check("wr_q_size", 64'(exp_wr_q.size()), 64'd1);
            end else begin
                wr = exp_wr_q.pop_front();
                check("mem_write", {Address, Write_Data}, wr);
            end
        end
        if (resp_valid && resp_ready) begin
            if (exp_resp_q.size() == 0) begin
                check("resp_q_size", 64'(exp_resp_q.size()), 64'd1);
            end else begin
                rs = exp_resp_q.pop_front();
                check("resp", {25'd0, resp_err, resp_tag, resp_data}, {25'd0, rs});
            end
        end
        if (st_err || st_err_exp) check("st_err", 64'(st_err), 64'(st_err_exp));
        st_err_exp = 1'b0;
        if (req_valid && req_ready) begin
            acc = 1'b1;
            if (req_is_store) begin
                if (req_addr[1:0] == 2'b00) begin
                    shadow[req_addr[7:2]] = req_wdata;
                    exp_wr_q.push_back({req_addr, req_wdata});
                end else begin
                    st_err_exp = 1'b1;
                end
            end else if (req_addr[1:0] != 2'b00) begin
                exp_resp_q.push_back({1'b1, req_tag, 32'd0});
            end else begin
                exp_resp_q.push_back({1'b0, req_tag, shadow[req_addr[7:2]]});
            end
        end
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic send(input logic st, input logic [31:0] a, input logic [31:0] d,
                        input logic [TAG_W-1:0] t);
        req_valid    = 1'b1;
        req_is_store = st;
        req_addr     = a;
        req_wdata    = d;
        req_tag      = t;
        for (int k = 0; k < 50; k++) begin
            cyc();
            if (acc) break;
        end
        check("send_accept", 64'(acc), 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic sync_model_after_reset();
        exp_wr_q.delete();
        exp_resp_q.delete();
        st_err_exp = 1'b0;
        for (int w = 0; w < 64; w++) shadow[w] = mem[w];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic rv;
        for (int w = 0; w < 64; w++) mem[w] = $urandom;
        mem[4] = 32'hA5A5A5A5;
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_tag      = '0;
        sb_drain_en  = 1'b1;
        resp_ready   = 1'b1;
        sync_model_after_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_flags", 64'({resp_valid, MemRead, MemWrite, st_err, sb_empty, resp_err}),
              64'b000010);
        check("reset_bus", {Address, Write_Data}, 64'd0);
        check("reset_resp", {26'd0, resp_tag, resp_data}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("ready_after_reset", 64'(req_ready), 64'd1);

        // Basic load latency: accept N, MemRead N+1, response N+2.
        send(1'b0, 32'h10, 32'd0, 6'd3);
        check("t1_memread", {31'd0, MemRead, Address}, {31'd0, 1'b1, 32'h10});
        cyc();
        check("t1_resp", {25'd0, resp_valid, resp_tag, resp_data}, {25'd0, 1'b1, 6'd3, 32'hA5A5A5A5});
        idle(2);

        // Store then load to the same word: write must precede the read.
        n0 = n_rd;
        send(1'b1, 32'h20, 32'hDEADBEEF, 6'd0);
        send(1'b0, 32'h20, 32'd0, 6'd5);
        idle(6);
        check("t2_one_read", 64'(n_rd - n0), 64'd1);
        check("t2_write_first", 64'(last_wr_cyc < last_rd_cyc), 64'd1);

        // Fill the buffer with draining off, then release it.
        sb_drain_en = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) send(1'b1, 32'h80 + 32'(i * 4), $urandom, 6'd0);
        check("t3_full", 64'({req_ready, sb_empty}), 64'd0);
        n0 = n_wr;
        req_valid = 1'b1; req_is_store = 1'b1; req_addr = 32'h90; req_wdata = 32'h5555AAAA;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("t3_held", 64'(acc), 64'd0);
        end
        sb_drain_en = 1'b1;
        #1;
        check("t3_pop_full_ready", 64'({MemWrite, req_ready}), 64'b10);
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (acc) break;
        end
        check("t3_fifth_accept", 64'(acc), 64'd1);
        req_valid = 1'b0;
        idle(8);
        check("t3_write_count", 64'(n_wr - n0), 64'd5);

        // Misaligned load and store.
        n0 = n_rd;
        send(1'b0, 32'h22, 32'd0, 6'd9);
        idle(4);
        check("t4_no_memread", 64'(n_rd - n0), 64'd0);
        send(1'b1, 32'h23, 32'h12345678, 6'd0);
        check("t4_st_err_pulse", 64'(st_err), 64'd1);
        cyc();
        check("t4_st_err_clear", 64'({st_err, sb_empty}), 64'b01);

`ifdef STORE_FWD_EN
        sb_drain_en = 1'b0;
        send(1'b1, 32'h40, 32'd1, 6'd0);
        send(1'b1, 32'h40, 32'd2, 6'd0);
        n0 = n_rd;
        send(1'b0, 32'h40, 32'd0, 6'd7);
        idle(4);
        check("t5_fwd_no_memread", 64'(n_rd - n0), 64'd0);
        sb_drain_en = 1'b1;
        idle(6);
`endif

        // Reset with stores still buffered: they must never reach memory.
        sb_drain_en = 1'b0;
        send(1'b1, 32'h60, 32'h11111111, 6'd0);
        send(1'b1, 32'h64, 32'h22222222, 6'd0);
        check("t6_buffered", 64'(sb_empty), 64'd0);
        n0 = n_wr;
        reset_n = 1'b0;
        sb_drain_en = 1'b1;
        @(negedge clk);
        #1;
        check("t6_reset_empty", 64'({sb_empty, MemWrite}), 64'b10);
        sync_model_after_reset();
        @(negedge clk);
        reset_n = 1'b1;
        idle(8);
        check("t6_no_write", 64'(n_wr - n0), 64'd0);

        // Random traffic with random drain gating and response back-pressure.
        for (int i = 0; i < 150; i++) begin
            rv           = ($urandom_range(0, 3) != 0);
            req_valid    = rv;
            req_is_store = 1'($urandom_range(0, 1));
            req_addr     = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 7) == 0) req_addr[1:0] = 2'($urandom_range(1, 3));
            req_wdata    = $urandom;
            req_tag      = TAG_W'($urandom_range(0, 63));
            for (int k = 0; k < 100; k++) begin
                sb_drain_en = ($urandom_range(0, 3) != 0);
                resp_ready  = ($urandom_range(0, 3) != 0);
                cyc();
                if (acc || !rv) break;
            end
            if (rv) check("rand_accept", 64'(acc), 64'd1);
            req_valid = 1'b0;
        end
        sb_drain_en = 1'b1;
        resp_ready  = 1'b1;
        idle(20);
        check("final_wr_q", 64'(exp_wr_q.size()), 64'd0);
        check("final_resp_q", 64'(exp_resp_q.size()), 64'd0);
        check("final_empty", 64'({sb_empty, resp_valid}), 64'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
